// File: rtl/saxi_resp_gather_4to1.sv
// AXI-lite control return path: broadcasts AR to four SLR slaves and gathers their R/B responses.
// Optional SAXI_RESP_GATHER_REG_OUT_EN adds a 2-entry registered skid on the upstream R and B outputs.
module saxi_resp_gather_fifo #(
    parameter int W     = 34,
    parameter int DEPTH = 2
) (
    input  logic         clk_i,
    input  logic         rst_ni,
    input  logic         push_i,
    input  logic [W-1:0] data_i,
    input  logic         pop_i,
    output logic         full_o,
    output logic         empty_o,
    output logic [W-1:0] data_o
);
    localparam int PW = $clog2(DEPTH);

    logic [DEPTH-1:0][W-1:0] mem_q;
    logic [PW-1:0]           wr_q, rd_q;
    logic [PW:0]             cnt_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            mem_q <= '0;
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else begin
            if (push_i) begin
                mem_q[wr_q] <= data_i;
                wr_q        <= wr_q + 1'b1;
            end
            if (pop_i) rd_q <= rd_q + 1'b1;
            case ({push_i, pop_i})
                2'b10:   cnt_q <= cnt_q + 1'b1;
                2'b01:   cnt_q <= cnt_q - 1'b1;
                default: cnt_q <= cnt_q;
            endcase
        end
    end

    assign full_o  = (cnt_q == (PW+1)'(DEPTH));
    assign empty_o = (cnt_q == '0);
    assign data_o  = mem_q[rd_q];
endmodule

module saxi_resp_gather_4to1 #(
    parameter int C_S_AXI_CONTROL_DATA_WIDTH = 32,
    parameter int C_S_AXI_CONTROL_ADDR_WIDTH = 9,
    parameter int FIFO_DEPTH                 = 2
) (
    input  logic                                  ap_clk,
    input  logic                                  ap_rst_n,
    input  logic                                  s_axi_control_ARVALID,
    output logic                                  s_axi_control_ARREADY,
    input  logic [C_S_AXI_CONTROL_ADDR_WIDTH-1:0] s_axi_control_ARADDR,
    output logic                                  s_axi_control_RVALID,
    input  logic                                  s_axi_control_RREADY,
    output logic [C_S_AXI_CONTROL_DATA_WIDTH-1:0] s_axi_control_RDATA,
    output logic [1:0]                            s_axi_control_RRESP,
    output logic                                  s_axi_control_BVALID,
    input  logic                                  s_axi_control_BREADY,
    output logic [1:0]                            s_axi_control_BRESP,
    output logic                                  s_axi_control_ARVALID_slr_0,
    input  logic                                  s_axi_control_ARREADY_slr_0,
    output logic [C_S_AXI_CONTROL_ADDR_WIDTH-1:0] s_axi_control_ARADDR_slr_0,
    input  logic                                  s_axi_control_RVALID_slr_0,
    output logic                                  s_axi_control_RREADY_slr_0,
    input  logic [C_S_AXI_CONTROL_DATA_WIDTH-1:0] s_axi_control_RDATA_slr_0,
    input  logic [1:0]                            s_axi_control_RRESP_slr_0,
    input  logic                                  s_axi_control_BVALID_slr_0,
    output logic                                  s_axi_control_BREADY_slr_0,
    input  logic [1:0]                            s_axi_control_BRESP_slr_0,
    output logic                                  s_axi_control_ARVALID_slr_1,
    input  logic                                  s_axi_control_ARREADY_slr_1,
    output logic [C_S_AXI_CONTROL_ADDR_WIDTH-1:0] s_axi_control_ARADDR_slr_1,
    input  logic                                  s_axi_control_RVALID_slr_1,
    output logic                                  s_axi_control_RREADY_slr_1,
    input  logic [C_S_AXI_CONTROL_DATA_WIDTH-1:0] s_axi_control_RDATA_slr_1,
    input  logic [1:0]                            s_axi_control_RRESP_slr_1,
    input  logic                                  s_axi_control_BVALID_slr_1,
    output logic                                  s_axi_control_BREADY_slr_1,
    input  logic [1:0]                            s_axi_control_BRESP_slr_1,
    output logic                                  s_axi_control_ARVALID_slr_2,
    input  logic                                  s_axi_control_ARREADY_slr_2,
    output logic [C_S_AXI_CONTROL_ADDR_WIDTH-1:0] s_axi_control_ARADDR_slr_2,
    input  logic                                  s_axi_control_RVALID_slr_2,
    output logic                                  s_axi_control_RREADY_slr_2,
    input  logic [C_S_AXI_CONTROL_DATA_WIDTH-1:0] s_axi_control_RDATA_slr_2,
    input  logic [1:0]                            s_axi_control_RRESP_slr_2,
    input  logic                                  s_axi_control_BVALID_slr_2,
    output logic                                  s_axi_control_BREADY_slr_2,
    input  logic [1:0]                            s_axi_control_BRESP_slr_2,
    output logic                                  s_axi_control_ARVALID_slr_3,
    input  logic                                  s_axi_control_ARREADY_slr_3,
    output logic [C_S_AXI_CONTROL_ADDR_WIDTH-1:0] s_axi_control_ARADDR_slr_3,
    input  logic                                  s_axi_control_RVALID_slr_3,
    output logic                                  s_axi_control_RREADY_slr_3,
    input  logic [C_S_AXI_CONTROL_DATA_WIDTH-1:0] s_axi_control_RDATA_slr_3,
    input  logic [1:0]                            s_axi_control_RRESP_slr_3,
    input  logic                                  s_axi_control_BVALID_slr_3,
    output logic                                  s_axi_control_BREADY_slr_3,
    input  logic [1:0]                            s_axi_control_BRESP_slr_3
);
    localparam int DW = C_S_AXI_CONTROL_DATA_WIDTH;

    logic [3:0]            ar_vld_s, ar_rdy_s, ar_done_q, ar_done_d;
    logic                  ar_hs;
    logic [3:0]            r_vld_s, r_rdy_s, r_push, r_full, r_empty;
    logic [3:0]            b_vld_s, b_rdy_s, b_push, b_full, b_empty;
    logic [3:0][DW-1:0]    r_data_s;
    logic [3:0][1:0]       r_resp_s, b_resp_s;
    logic [3:0][DW+1:0]    r_head;
    logic [3:0][1:0]       b_head;
    logic                  r_pop, b_pop, m_rvalid, m_bvalid;
    logic [DW-1:0]         m_rdata, up_rdata;
    logic [1:0]            m_rresp, m_bresp, up_rresp, up_bresp;
    logic                  up_rvalid, up_bvalid;

    assign ar_rdy_s = {s_axi_control_ARREADY_slr_3, s_axi_control_ARREADY_slr_2,
                       s_axi_control_ARREADY_slr_1, s_axi_control_ARREADY_slr_0};
    assign r_vld_s  = {s_axi_control_RVALID_slr_3, s_axi_control_RVALID_slr_2,
                       s_axi_control_RVALID_slr_1, s_axi_control_RVALID_slr_0};
    assign r_data_s = {s_axi_control_RDATA_slr_3, s_axi_control_RDATA_slr_2,
                       s_axi_control_RDATA_slr_1, s_axi_control_RDATA_slr_0};
    assign r_resp_s = {s_axi_control_RRESP_slr_3, s_axi_control_RRESP_slr_2,
                       s_axi_control_RRESP_slr_1, s_axi_control_RRESP_slr_0};
    assign b_vld_s  = {s_axi_control_BVALID_slr_3, s_axi_control_BVALID_slr_2,
                       s_axi_control_BVALID_slr_1, s_axi_control_BVALID_slr_0};
    assign b_resp_s = {s_axi_control_BRESP_slr_3, s_axi_control_BRESP_slr_2,
                       s_axi_control_BRESP_slr_1, s_axi_control_BRESP_slr_0};

    // Sticky per-slave acceptance: each slave sees one AR, upstream completes once all have taken it.
    assign ar_vld_s              = {4{s_axi_control_ARVALID & ap_rst_n}} & ~ar_done_q;
    assign s_axi_control_ARREADY = ap_rst_n & (&(ar_done_q | ar_rdy_s));
    assign ar_hs                 = s_axi_control_ARVALID & s_axi_control_ARREADY;
    assign ar_done_d             = ar_hs ? 4'b0 : (ar_done_q | (ar_vld_s & ar_rdy_s));

    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) ar_done_q <= '0;
        else           ar_done_q <= ar_done_d;
    end

    assign {s_axi_control_ARVALID_slr_3, s_axi_control_ARVALID_slr_2,
            s_axi_control_ARVALID_slr_1, s_axi_control_ARVALID_slr_0} = ar_vld_s;
    assign s_axi_control_ARADDR_slr_0 = s_axi_control_ARADDR;
    assign s_axi_control_ARADDR_slr_1 = s_axi_control_ARADDR;
    assign s_axi_control_ARADDR_slr_2 = s_axi_control_ARADDR;
    assign s_axi_control_ARADDR_slr_3 = s_axi_control_ARADDR;

    for (genvar k = 0; k < 4; k++) begin : g_slr
        assign r_rdy_s[k] = ap_rst_n & (~r_full[k] | r_pop);
        assign r_push[k]  = r_vld_s[k] & r_rdy_s[k];
        assign b_rdy_s[k] = ap_rst_n & (~b_full[k] | b_pop);
        assign b_push[k]  = b_vld_s[k] & b_rdy_s[k];

        saxi_resp_gather_fifo #(.W(DW+2), .DEPTH(FIFO_DEPTH)) u_rfifo (
            .clk_i(ap_clk), .rst_ni(ap_rst_n), .push_i(r_push[k]),
            .data_i({r_data_s[k], r_resp_s[k]}), .pop_i(r_pop),
            .full_o(r_full[k]), .empty_o(r_empty[k]), .data_o(r_head[k]));
        saxi_resp_gather_fifo #(.W(2), .DEPTH(FIFO_DEPTH)) u_bfifo (
            .clk_i(ap_clk), .rst_ni(ap_rst_n), .push_i(b_push[k]),
            .data_i(b_resp_s[k]), .pop_i(b_pop),
            .full_o(b_full[k]), .empty_o(b_empty[k]), .data_o(b_head[k]));
    end

    assign {s_axi_control_RREADY_slr_3, s_axi_control_RREADY_slr_2,
            s_axi_control_RREADY_slr_1, s_axi_control_RREADY_slr_0} = r_rdy_s;
    assign {s_axi_control_BREADY_slr_3, s_axi_control_BREADY_slr_2,
            s_axi_control_BREADY_slr_1, s_axi_control_BREADY_slr_0} = b_rdy_s;

    // Response codes are ordered by severity, so the worst case is the numeric max.
    always_comb begin
        m_rdata = '0;
        m_rresp = '0;
        m_bresp = '0;
        for (int k = 0; k < 4; k++) begin
            m_rdata = m_rdata | r_head[k][DW+1:2];
            if (r_head[k][1:0] > m_rresp) m_rresp = r_head[k][1:0];
            if (b_head[k] > m_bresp)      m_bresp = b_head[k];
        end
    end

    assign m_rvalid = ~|r_empty;
    assign m_bvalid = ~|b_empty;

`ifdef SAXI_RESP_GATHER_REG_OUT_EN
    logic rskid_full, rskid_empty, bskid_full, bskid_empty;

    assign r_pop = m_rvalid & ~rskid_full;
    assign b_pop = m_bvalid & ~bskid_full;

    saxi_resp_gather_fifo #(.W(DW+2), .DEPTH(2)) u_rskid (
        .clk_i(ap_clk), .rst_ni(ap_rst_n), .push_i(r_pop),
        .data_i({m_rdata, m_rresp}), .pop_i(up_rvalid & s_axi_control_RREADY),
        .full_o(rskid_full), .empty_o(rskid_empty), .data_o({up_rdata, up_rresp}));
    saxi_resp_gather_fifo #(.W(2), .DEPTH(2)) u_bskid (
        .clk_i(ap_clk), .rst_ni(ap_rst_n), .push_i(b_pop),
        .data_i(m_bresp), .pop_i(up_bvalid & s_axi_control_BREADY),
        .full_o(bskid_full), .empty_o(bskid_empty), .data_o(up_bresp));

    assign up_rvalid = ~rskid_empty;
    assign up_bvalid = ~bskid_empty;
`else
    assign r_pop     = m_rvalid & s_axi_control_RREADY;
    assign b_pop     = m_bvalid & s_axi_control_BREADY;
    assign up_rvalid = m_rvalid;
    assign up_bvalid = m_bvalid;
    assign up_rdata  = m_rdata;
    assign up_rresp  = m_rresp;
    assign up_bresp  = m_bresp;
`endif

    // Payload is forced to zero whenever no response is being presented.
    assign s_axi_control_RVALID = up_rvalid;
    assign s_axi_control_RDATA  = up_rvalid ? up_rdata : '0;
    assign s_axi_control_RRESP  = up_rvalid ? up_rresp : 2'b0;
    assign s_axi_control_BVALID = up_bvalid;
    assign s_axi_control_BRESP  = up_bvalid ? up_bresp : 2'b0;
endmodule

// File: tb/tb_saxi_resp_gather_4to1.sv
// Scoreboard bench for saxi_resp_gather_4to1: expected merged responses queued at stimulus, checked on handshake.
module tb_saxi_resp_gather_4to1;
`ifdef SAXI_RESP_GATHER_REG_OUT_EN
    localparam int SKID = 2;
`else
    localparam int SKID = 0;
`endif
    localparam int RISE  = 8 + SKID / 2;
    localparam int NFILL = 2 + SKID;

    logic clk = 1'b0, rst_n = 1'b0;
    logic arvalid, rready, bready;
    logic [8:0] araddr;
    wire  arready, rvalid, bvalid;
    wire  [31:0] rdata;
    wire  [1:0] rresp, bresp;
    logic [3:0] s_arready, s_rvalid, s_bvalid;
    logic [3:0][31:0] s_rdata;
    logic [3:0][1:0] s_rresp, s_bresp;
    wire  [3:0] s_arvalid, s_rready, s_bready;
    wire  [3:0][8:0] s_araddr;

    int n_cmp = 0, n_err = 0;
    int ar_cnt[4];
    int ar_up = 0, b_hs = 0, r_hs = 0, b0;
    logic [33:0] rq[$];
    logic [1:0]  bq[$];
    logic [3:0][31:0] d;
    logic [3:0][1:0] rs;

    always #5 clk = ~clk;

    saxi_resp_gather_4to1 dut (
        .ap_clk(clk), .ap_rst_n(rst_n),
        .s_axi_control_ARVALID(arvalid), .s_axi_control_ARREADY(arready), .s_axi_control_ARADDR(araddr),
        .s_axi_control_RVALID(rvalid), .s_axi_control_RREADY(rready), .s_axi_control_RDATA(rdata),
        .s_axi_control_RRESP(rresp), .s_axi_control_BVALID(bvalid), .s_axi_control_BREADY(bready),
        .s_axi_control_BRESP(bresp),
        .s_axi_control_ARVALID_slr_0(s_arvalid[0]), .s_axi_control_ARREADY_slr_0(s_arready[0]),
        .s_axi_control_ARADDR_slr_0(s_araddr[0]), .s_axi_control_RVALID_slr_0(s_rvalid[0]),
        .s_axi_control_RREADY_slr_0(s_rready[0]), .s_axi_control_RDATA_slr_0(s_rdata[0]),
        .s_axi_control_RRESP_slr_0(s_rresp[0]), .s_axi_control_BVALID_slr_0(s_bvalid[0]),
        .s_axi_control_BREADY_slr_0(s_bready[0]), .s_axi_control_BRESP_slr_0(s_bresp[0]),
        .s_axi_control_ARVALID_slr_1(s_arvalid[1]), .s_axi_control_ARREADY_slr_1(s_arready[1]),
        .s_axi_control_ARADDR_slr_1(s_araddr[1]), .s_axi_control_RVALID_slr_1(s_rvalid[1]),
        .s_axi_control_RREADY_slr_1(s_rready[1]), .s_axi_control_RDATA_slr_1(s_rdata[1]),
        .s_axi_control_RRESP_slr_1(s_rresp[1]), .s_axi_control_BVALID_slr_1(s_bvalid[1]),
        .s_axi_control_BREADY_slr_1(s_bready[1]), .s_axi_control_BRESP_slr_1(s_bresp[1]),
        .s_axi_control_ARVALID_slr_2(s_arvalid[2]), .s_axi_control_ARREADY_slr_2(s_arready[2]),
        .s_axi_control_ARADDR_slr_2(s_araddr[2]), .s_axi_control_RVALID_slr_2(s_rvalid[2]),
        .s_axi_control_RREADY_slr_2(s_rready[2]), .s_axi_control_RDATA_slr_2(s_rdata[2]),
        .s_axi_control_RRESP_slr_2(s_rresp[2]), .s_axi_control_BVALID_slr_2(s_bvalid[2]),
        .s_axi_control_BREADY_slr_2(s_bready[2]), .s_axi_control_BRESP_slr_2(s_bresp[2]),
        .s_axi_control_ARVALID_slr_3(s_arvalid[3]), .s_axi_control_ARREADY_slr_3(s_arready[3]),
        .s_axi_control_ARADDR_slr_3(s_araddr[3]), .s_axi_control_RVALID_slr_3(s_rvalid[3]),
        .s_axi_control_RREADY_slr_3(s_rready[3]), .s_axi_control_RDATA_slr_3(s_rdata[3]),
        .s_axi_control_RRESP_slr_3(s_rresp[3]), .s_axi_control_BVALID_slr_3(s_bvalid[3]),
        .s_axi_control_BREADY_slr_3(s_bready[3]), .s_axi_control_BRESP_slr_3(s_bresp[3])
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h @%0t", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [33:0] merge_r(input logic [3:0][31:0] dd, input logic [3:0][1:0] rr);
        logic [31:0] o = '0;
        logic [1:0]  m = '0;
        for (int k = 0; k < 4; k++) begin
            o = o | dd[k];
            if (rr[k] > m) m = rr[k];
        end
        return {o, m};
    endfunction

    function automatic logic [1:0] worst(input logic [3:0][1:0] rr);
        logic [1:0] m = '0;
        for (int k = 0; k < 4; k++) if (rr[k] > m) m = rr[k];
        return m;
    endfunction

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    always @(negedge clk) if (rst_n) begin
        for (int k = 0; k < 4; k++) if (s_arvalid[k] && s_arready[k]) ar_cnt[k]++;
        if (arvalid && arready) ar_up++;
        if (bvalid && bready) begin
            b_hs++;
            if (bq.size() == 0) chk("b_unexpected", bq.size(), 1);
            else chk("bresp", bresp, bq.pop_front());
        end
        if (rvalid && rready) begin
            r_hs++;
            if (rq.size() == 0) chk("r_unexpected", rq.size(), 1);
            else begin
                logic [33:0] e;
                e = rq.pop_front();
                chk("rdata", rdata, e[33:2]);
                chk("rresp", rresp, e[1:0]);
            end
        end
    end

    task automatic ar_send(input logic [8:0] a);
        int n = 0;
        araddr = a;
        arvalid = 1'b1;
        @(negedge clk);
        while (!arready && n < 50) begin @(negedge clk); n++; end
        if (n >= 50) chk("ar_send_timeout", arready, 1);
        tick;
        arvalid = 1'b0;
    endtask

    task automatic r_send(input logic [3:0][31:0] dd, input logic [3:0][1:0] rr);
        int n = 0;
        rq.push_back(merge_r(dd, rr));
        s_rdata = dd;
        s_rresp = rr;
        s_rvalid = 4'hF;
        @(negedge clk);
        while (s_rready != 4'hF && n < 50) begin @(negedge clk); n++; end
        if (n >= 50) chk("r_send_timeout", s_rready, 4'hF);
        tick;
        s_rvalid = 4'h0;
    endtask

    task automatic b_send(input logic [3:0][1:0] rr);
        int n = 0;
        bq.push_back(worst(rr));
        s_bresp = rr;
        s_bvalid = 4'hF;
        @(negedge clk);
        while (s_bready != 4'hF && n < 50) begin @(negedge clk); n++; end
        if (n >= 50) chk("b_send_timeout", s_bready, 4'hF);
        tick;
        s_bvalid = 4'h0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete @%0t", $time);
        $fatal(1);
    end

    initial begin
        arvalid = 0; araddr = '0; rready = 1; bready = 1;
        s_arready = 4'hF; s_rvalid = 0; s_bvalid = 0;
        s_rdata = '0; s_rresp = '0; s_bresp = '0;
        for (int k = 0; k < 4; k++) ar_cnt[k] = 0;
        #23;
        chk("rst_rvalid", rvalid, 0);
        chk("rst_bvalid", bvalid, 0);
        chk("rst_arready", arready, 0);
        chk("rst_rready_slr", s_rready, 0);
        chk("rst_bready_slr", s_bready, 0);
        chk("rst_rdata", rdata, 0);
        rst_n = 1'b1;
        tick;

        // Staggered B arrivals on cycles 1,3,4,7.
        b0 = b_hs;
        for (int c = 1; c <= RISE + 1; c++) begin
            tick;
            s_bvalid = {c == 7, c == 4, c == 3, c == 1};
            if (c == 7) bq.push_back(2'b00);
            @(negedge clk);
            chk("b_stagger_valid", bvalid, c == RISE);
        end
        tick;
        s_bvalid = 0;
        chk("b_stagger_count", b_hs - b0, 1);

        // Worst-case BRESP merge.
        b_send({2'd0, 2'd2, 2'd0, 2'd0});
        b_send({2'd2, 2'd0, 2'd3, 2'd0});
        repeat (4) tick;

        // Staggered AR acceptance: only slr_1 ready for three cycles.
        for (int k = 0; k < 4; k++) ar_cnt[k] = 0;
        ar_up = 0;
        araddr = 9'h010; arvalid = 1; s_arready = 4'b0010;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            chk("ar_up_ready_low", arready, 0);
            chk("ar_slr_valid", s_arvalid, (c == 0) ? 4'hF : 4'hD);
            tick;
        end
        s_arready = 4'hF;
        @(negedge clk);
        chk("ar_up_ready_high", arready, 1);
        chk("ar_slr_valid_last", s_arvalid, 4'hD);
        for (int k = 0; k < 4; k++) chk("ar_slr_addr", s_araddr[k], 9'h010);
        tick;
        arvalid = 0;
        @(negedge clk);
        for (int k = 0; k < 4; k++) chk("ar_slr_count", ar_cnt[k], 1);
        chk("ar_up_count", ar_up, 1);
        tick;
        araddr = 9'h1A0; arvalid = 1;
        @(negedge clk);
        chk("ar_done_cleared", s_arvalid, 4'hF);
        chk("ar_up_ready_next", arready, 1);
        tick;
        arvalid = 0;

        // Read merge: single owner and mixed OR/max.
        ar_send(9'h020);
        r_send({32'h0, 32'hDEADBEEF, 32'h0, 32'h0}, '0);
        ar_send(9'h024);
        r_send({32'h0, 32'h0, 32'h0F00_0000, 32'h0000_00F0}, {2'd2, 2'd0, 2'd0, 2'd1});
        repeat (4) tick;

        // Backpressure: fill the buffers, then release.
        rready = 0;
        for (int i = 0; i < NFILL; i++) begin
            d = '0;
            d[i % 4] = $urandom();
            for (int k = 0; k < 4; k++) rs[k] = 2'($urandom_range(0, 3));
            ar_send(9'(i * 4));
            r_send(d, rs);
        end
        @(negedge clk);
        chk("bp_slr_ready_low", s_rready, 4'h0);
        tick;
        d = '0;
        d[3] = 32'hCAFE_0003;
        rs = {2'd1, 2'd0, 2'd0, 2'd0};
        fork
            r_send(d, rs);
            begin
                tick; tick;
                chk("bp_still_held", s_rready, 4'h0);
                rready = 1;
            end
        join
        repeat (6) tick;
        chk("bp_queue_drained", rq.size(), 0);

        // Reset with only slr_0 holding a response.
        s_rdata = '0;
        s_rdata[0] = 32'hAAAA_5555;
        s_rvalid = 4'b0001;
        tick;
        s_rvalid = 0;
        @(negedge clk);
        rst_n = 0;
        #1;
        chk("mid_rst_rvalid", rvalid, 0);
        chk("mid_rst_bvalid", bvalid, 0);
        chk("mid_rst_arready", arready, 0);
        chk("mid_rst_slr_ready", s_rready, 0);
        chk("mid_rst_rdata", rdata, 0);
        tick; tick;
        rst_n = 1;
        tick;
        ar_send(9'h030);
        r_send({32'h0, 32'h0, 32'h1234_5678, 32'h0}, '0);
        repeat (5) tick;

        chk("r_queue_left", rq.size(), 0);
        chk("b_queue_left", bq.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
